// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS32 multicycle control FSM: states, opcodes,
// datapath mux codes and trap causes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP, S_TRAP
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_SLT = 2'b11
    } aluOpT;

    typedef enum logic [1:0] {
        PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10
    } pcSourceT;

    typedef enum logic [1:0] {
        SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SHL2 = 2'b11
    } aluSrcBT;

    typedef enum logic [1:0] {
        TC_NONE = 2'b00, TC_ILLEGAL = 2'b01, TC_MEM_TIMEOUT = 2'b10
    } trapCauseT;

    // States that hold the unified memory port and wait on mem_ready.
    function automatic logic isWaitState(stateT s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle; master is the controller, slave the datapath.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_en;
    logic [1:0]       pc_source;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instr_retired;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_en, pc_source,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               trap, trap_cause, instr_retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_en, pc_source,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
               trap, trap_cause, instr_retired
    );
endinterface

// File: rtl/ctrl_wait_timer.sv
// Clear/enable wait counter; flags the cycle on which the wait budget runs out.
module ctrl_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    // This cycle's increment would make the count reach MEM_TIMEOUT.
    assign expired = en && (cnt == LAST);
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the MIPS32 multicycle datapath with memory-wait timeout
// and illegal-opcode trap.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);
    stateT            state;
    trapCauseT        trapCause;
    logic [CNT_W-1:0] instrRetired;
    logic             waiting;
    logic             timeout;

    assign waiting = isWaitState(state) && !bus.mem_ready;

    ctrl_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) waitTimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!waiting),
        .en      (waiting),
        .expired (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            trapCause    <= TC_NONE;
            instrRetired <= '0;
        end else begin
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        state <= S_DECODE;
                    end else if (timeout) begin
                        state     <= S_TRAP;
                        trapCause <= TC_MEM_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    case (bus.opcode)
                        OP_RTYPE:        state <= S_EXEC;
                        OP_LW, OP_SW:    state <= S_MEMADR;
                        OP_ADDI, OP_SLTI: state <= S_IMMEX;
                        OP_BEQ, OP_BNE:  state <= S_BRANCH;
                        OP_J:            state <= S_JUMP;
                        default: begin
                            state     <= S_TRAP;
                            trapCause <= TC_ILLEGAL;
                        end
                    endcase
                end
                S_MEMADR: state <= (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (bus.mem_ready) begin
                        state <= S_MEMWB;
                    end else if (timeout) begin
                        state     <= S_TRAP;
                        trapCause <= TC_MEM_TIMEOUT;
                    end
                end
                S_MEMWR: begin
                    if (bus.mem_ready) begin
                        state        <= S_FETCH;
                        instrRetired <= instrRetired + CNT_W'(1);
                    end else if (timeout) begin
                        state     <= S_TRAP;
                        trapCause <= TC_MEM_TIMEOUT;
                    end
                end
                S_EXEC:   state <= S_ALUWB;
                S_IMMEX:  state <= S_IMMWB;
                S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP: begin
                    state        <= S_FETCH;
                    instrRetired <= instrRetired + CNT_W'(1);
                end
                S_TRAP:   state <= S_TRAP;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_en      = 1'b0;
        bus.pc_source  = PC_ALU;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_RT;
        bus.alu_op     = ALU_ADD;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
                bus.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: bus.alu_src_b = SRCB_IMM_SHL2;
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_IMMEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_IMMWB: bus.reg_write = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_SUB;
                bus.pc_source = PC_ALUOUT;
                bus.pc_en     = (bus.opcode == OP_BEQ) ? bus.zero : !bus.zero;
            end
            S_JUMP: begin
                bus.pc_source = PC_JUMP;
                bus.pc_en     = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.trap          = (state == S_TRAP);
    assign bus.trap_cause    = trapCause;
    assign bus.instr_retired = instrRetired;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_mips_multicycle_ctrl;

    typedef enum int {
        T_IDLE, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
        T_EXEC, T_ALUWB, T_IMMEX, T_IMMWB, T_BRANCH, T_JUMP, T_TRAP
    } tbState;

    typedef struct packed {
        logic        mem_read, mem_write, iord, ir_write, pc_en;
        logic [1:0]  pc_source;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic [1:0]  alu_op;
        logic        reg_dst, mem_to_reg, reg_write, trap;
        logic [1:0]  trap_cause;
        logic [31:0] instr_retired;
    } outT;

    typedef struct {
        int    cyc;
        string name;
        outT   exp;
    } expT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'b000000;
    logic        zero = 1'b0;
    logic        memReady = 1'b1;

    logic [31:0] expRetired = '0;
    logic [1:0]  expCause = 2'b00;
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;
    expT         expQ[$];

    mips_multicycle_ctrl_if #(.CNT_W(32)) bus ();

    assign bus.opcode    = opcode;
    assign bus.zero      = zero;
    assign bus.mem_ready = memReady;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Expected outputs for a state under the currently driven inputs.
    function automatic outT model(tbState s);
        outT o = '0;
        o.instr_retired = expRetired;
        o.trap_cause    = expCause;
        case (s)
            T_FETCH:  begin o.mem_read = 1; o.ir_write = memReady; o.pc_en = memReady; o.alu_src_b = 2'b01; end
            T_DECODE: o.alu_src_b = 2'b11;
            T_MEMADR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            T_MEMRD:  begin o.mem_read = 1; o.iord = 1; end
            T_MEMWB:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            T_MEMWR:  begin o.mem_write = 1; o.iord = 1; end
            T_EXEC:   begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            T_ALUWB:  begin o.reg_write = 1; o.reg_dst = 1; end
            T_IMMEX:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = (opcode == 6'b001010) ? 2'b11 : 2'b00; end
            T_IMMWB:  o.reg_write = 1;
            T_BRANCH: begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_en = (opcode == 6'b000100) ? zero : ~zero; end
            T_JUMP:   begin o.pc_source = 2'b10; o.pc_en = 1; end
            T_TRAP:   o.trap = 1;
            default:  ;
        endcase
        return o;
    endfunction

    task automatic step(input tbState s, input string nm);
        expQ.push_back('{cyc: cycle, name: nm, exp: model(s)});
        @(posedge clk); #1;
        if (rst_n && (s inside {T_MEMWB, T_ALUWB, T_IMMWB, T_BRANCH, T_JUMP} || (s == T_MEMWR && memReady)))
            expRetired++;
    endtask

    task automatic resetPulse();
        rst_n = 1'b0;
        expRetired = '0;
        expCause = 2'b00;
        step(T_IDLE, "reset_held");
        rst_n = 1'b1;
        step(T_IDLE, "idle_after_reset");
    endtask

    always @(negedge clk) begin
        outT act;
        expT e;
        act = {bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_en, bus.pc_source,
               bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_dst, bus.mem_to_reg,
               bus.reg_write, bus.trap, bus.trap_cause, bus.instr_retired};
        while (expQ.size() > 0 && expQ[0].cyc <= cycle) begin
            e = expQ.pop_front();
            checks++;
            if (e.cyc != cycle) begin
                errors++;
                $display("FAIL %s: sampled in cycle %0d, required cycle %0d", e.name, cycle, e.cyc);
            end else if (act !== e.exp) begin
                errors++;
                $display("FAIL %s (cycle %0d): got %h required %h", e.name, cycle, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        step(T_IDLE, "reset_state");
        rst_n = 1'b1;
        step(T_IDLE, "idle_after_release");

        // R-type with memory always ready
        opcode = 6'b000000;
        step(T_FETCH, "r_fetch"); step(T_DECODE, "r_decode");
        step(T_EXEC, "r_exec");   step(T_ALUWB, "r_aluwb");

        // LW with three wait cycles in MEMRD
        opcode = 6'b100011;
        step(T_FETCH, "lw_fetch"); step(T_DECODE, "lw_decode"); step(T_MEMADR, "lw_memadr");
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) step(T_MEMRD, "lw_memrd_wait");
        memReady = 1'b1;
        step(T_MEMRD, "lw_memrd_done"); step(T_MEMWB, "lw_memwb");

        // BNE and BEQ with zero set
        zero = 1'b1;
        opcode = 6'b000101;
        step(T_FETCH, "bne_fetch"); step(T_DECODE, "bne_decode"); step(T_BRANCH, "bne_not_taken");
        opcode = 6'b000100;
        step(T_FETCH, "beq_fetch"); step(T_DECODE, "beq_decode"); step(T_BRANCH, "beq_taken");
        zero = 1'b0;

        // SW, ADDI, SLTI, J
        opcode = 6'b101011;
        step(T_FETCH, "sw_fetch"); step(T_DECODE, "sw_decode"); step(T_MEMADR, "sw_memadr"); step(T_MEMWR, "sw_memwr");
        opcode = 6'b001000;
        step(T_FETCH, "addi_fetch"); step(T_DECODE, "addi_decode"); step(T_IMMEX, "addi_immex"); step(T_IMMWB, "addi_immwb");
        opcode = 6'b001010;
        step(T_FETCH, "slti_fetch"); step(T_DECODE, "slti_decode"); step(T_IMMEX, "slti_immex"); step(T_IMMWB, "slti_immwb");
        opcode = 6'b000010;
        step(T_FETCH, "j_fetch"); step(T_DECODE, "j_decode"); step(T_JUMP, "j_jump");

        // mem_ready on the timeout cycle wins
        opcode = 6'b000000;
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) step(T_FETCH, "fetch_wait");
        memReady = 1'b1;
        step(T_FETCH, "fetch_ready_at_limit"); step(T_DECODE, "limit_decode");
        step(T_EXEC, "limit_exec"); step(T_ALUWB, "limit_aluwb");

        // Reset dropped during a stalled SW write
        opcode = 6'b101011;
        step(T_FETCH, "sw2_fetch"); step(T_DECODE, "sw2_decode"); step(T_MEMADR, "sw2_memadr");
        memReady = 1'b0;
        step(T_MEMWR, "sw2_memwr_wait");
        rst_n = 1'b0;
        expRetired = '0;
        expCause = 2'b00;
        step(T_IDLE, "async_reset_in_memwr");
        rst_n = 1'b1;
        step(T_IDLE, "idle_after_mid_reset");

        // Fetch timeout trap after the 4th wait cycle
        for (int i = 0; i < 4; i++) step(T_FETCH, "fetch_stall");
        expCause = 2'b10;
        step(T_TRAP, "trap_timeout");
        memReady = 1'b1;
        step(T_TRAP, "trap_timeout_sticky");

        // Illegal opcode trap, held regardless of inputs
        resetPulse();
        opcode = 6'b111111;
        step(T_FETCH, "ill_fetch"); step(T_DECODE, "ill_decode");
        expCause = 2'b01;
        step(T_TRAP, "trap_illegal");
        memReady = 1'b0;
        step(T_TRAP, "trap_illegal_held");
        opcode = 6'b000000;
        step(T_TRAP, "trap_illegal_held2");
        memReady = 1'b1;
        resetPulse();
        step(T_FETCH, "fetch_after_trap");

        @(negedge clk); #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, required 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the shared MIPS32 multicycle datapath: PC, IR, register file, ALU and a single unified memory port.
- Steps each instruction through fetch/decode/execute/memory/writeback and drives every datapath mux and write enable.
- Waits on a variable-latency memory ready handshake, counts retired instructions, and traps on illegal opcodes or a memory timeout.

Parameters:
- MEM_TIMEOUT, 255, max cycles a memory state may wait for mem_ready before trapping (≥1)
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26] from datapath; valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory completes current read/write this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  address mux: 0=PC, 1=ALUOut
- ir_write  out  1  IR load enable
- pc_en  out  1  PC load enable (branch condition already folded in)
- pc_source  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct-decode, 11=set-less-than
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- reg_write  out  1  register file write enable
- trap  out  1  sticky fault flag
- trap_cause  out  2  00=none, 01=illegal opcode, 10=memory timeout
- instr_retired  out  CNT_W  retired-instruction count, wraps

Behaviour:
- Reset (async, rst_n=0): state=IDLE, instr_retired=0, wait counter=0, trap_cause=00. All outputs 0.
- Outputs decode from the state register. In memory-wait states, ir_write and pc_en also depend on mem_ready (same-cycle gating). Any signal not listed for a state is 0.
- IDLE: all outputs 0; next state FETCH unconditionally, so the first fetch request appears 1 cycle after reset release.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_en=mem_ready.
  - If mem_ready, go to DECODE; else stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Dispatch on opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 001000 or 001010 -> IMMEX
  - 000100 or 000101 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> TRAP, cause 01
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: LW -> MEMRD, SW -> MEMWR.
- MEMRD: mem_read=1, iord=1. Wait for mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEMWR: mem_write=1, iord=1. Wait for mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next ALUWB.
- ALUWB: reg_write=1, reg_dst=1. Next FETCH.
- IMMEX: alu_src_a=1, alu_src_b=10, alu_op=00 for ADDI, 11 for SLTI. Next IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
  - pc_en = zero for BEQ, ~zero for BNE.
  - Next FETCH.
- JUMP: pc_source=10, pc_en=1. Next FETCH.
- TRAP: all datapath outputs 0, trap=1. Held until reset.
- Retire: instr_retired increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, IMMWB, BRANCH or JUMP, whether or not a branch is taken. It wraps at 2^CNT_W.
- Timeout:
  - The wait counter clears on entry to FETCH, MEMRD and MEMWR.
  - It increments each cycle spent in one of those states with mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, the FSM goes to TRAP with cause 10.
  - If mem_ready=1 and the timeout condition occur in the same cycle, mem_ready wins and there is no trap.
- Cycle counts with mem_ready tied to 1: R/ADDI/SLTI 4 cycles, LW 5, SW 4, BEQ/BNE/J 3.
- Reset asserted mid-instruction: the FSM goes immediately to IDLE and all outputs drop to 0 asynchronously. No partial register or memory write completes after rst_n falls.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encoding enum (4-bit: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IMMEX, IMMWB, BRANCH, JUMP, TRAP)
  - opcode constants
  - ALUOp, PCSource and ALUSrcB codes
  - trap cause codes
- One sub-module, ctrl_wait_timer: a clear/enable counter with a timeout compare against MEM_TIMEOUT.

Test Plan:
- mem_ready=1, opcode=000000 -> states IDLE,FETCH,DECODE,EXEC,ALUWB,FETCH; reg_write=1, reg_dst=1 in ALUWB; instr_retired 0->1.
- LW (100011), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_read=iord=1 throughout; MEMWB asserts reg_write=1, mem_to_reg=1.
- BNE (000101) with zero=1 -> pc_en=0 in BRANCH; BEQ (000100) with zero=1 -> pc_en=1, pc_source=01; both increment instr_retired.
- SLTI (001010) -> alu_op=11, alu_src_b=10 in IMMEX; opcode 111111 -> TRAP, trap=1, trap_cause=01, stays there until rst_n pulse.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> TRAP with cause 10 after the 4th wait cycle. Repeat with mem_ready=1 on that same cycle -> DECODE, no trap.
- rst_n dropped during MEMWR -> mem_write falls to 0 asynchronously; after release: IDLE then FETCH, instr_retired=0.
